// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: geometry, end-of-program marker and
// the loader state encoding used by the write-side loader.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 64;
  localparam int unsigned IMEM_ADDR_W = 6;
  localparam logic [31:0] IMEM_TERM   = 32'hFFFF_FFFF;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    TERM,
    DONE
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Four-lane big-endian byte packer: lane 0 lands in bits [31:24]; a word is
// complete after lane 3 or after a byte flagged last (lower lanes stay zero).
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  input  logic              last,
  output logic [WORD_W-1:0] word_c,
  output logic              full_c,
  output logic              last_seen
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        idx_q;

  // Word as it will look once the byte on the input is taken.
  always_comb begin
    word_c = word_q;
    if (load) begin
      case (idx_q)
        2'd0:    word_c[31:24] = data;
        2'd1:    word_c[23:16] = data;
        2'd2:    word_c[15:8]  = data;
        default: word_c[7:0]   = data;
      endcase
    end
  end

  assign full_c = load && ((idx_q == 2'd3) || last);

  // Clearing to zero between words provides the zero padding of partial words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      idx_q     <= 2'd0;
      last_seen <= 1'b0;
    end else if (clear) begin
      word_q    <= '0;
      idx_q     <= 2'd0;
      last_seen <= 1'b0;
    end else if (load) begin
      word_q <= word_c;
      idx_q  <= idx_q + 2'd1;
      if (last) begin
        last_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them from
// address 0, appends the terminator and releases cpu_hold when complete.
// Optional running XOR checksum output enabled by IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] TERM_WORD = IMEM_TERM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_ovf,
  output logic              err_term
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_e     state_q, state_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [31:0]       mem_wdata_d;
  logic [CNT_W-1:0]  word_cnt_d;
  logic              cpu_hold_d;
  logic              done_d;
  logic              err_ovf_d;
  logic              err_term_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0]       csum_d;
`endif

  logic              accept;
  logic              pk_clear;
  logic [31:0]       pk_word_c;
  logic              pk_full_c;
  logic              pk_last_seen;

  assign in_ready = (state_q == ASSEMBLE);
  assign accept   = in_valid && in_ready;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (accept),
    .data      (in_data),
    .last      (in_last),
    .word_c    (pk_word_c),
    .full_c    (pk_full_c),
    .last_seen (pk_last_seen)
  );

  // Next-state and next-output decode; write strobes are staged one cycle ahead.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;
    word_cnt_d  = word_cnt;
    cpu_hold_d  = cpu_hold;
    done_d      = done;
    err_ovf_d   = err_ovf;
    err_term_d  = err_term;
    pk_clear    = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d      = csum;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = ASSEMBLE;
          pk_clear   = 1'b1;
          word_cnt_d = '0;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_ovf_d  = 1'b0;
          err_term_d = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ASSEMBLE: begin
        if (pk_full_c) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_waddr_d = ADDR_W'(word_cnt);
          mem_wdata_d = pk_word_c;
        end
      end
      WRITE: begin
        pk_clear   = 1'b1;
        word_cnt_d = word_cnt + CNT_W'(1);
        if (mem_wdata == TERM_WORD) begin
          err_term_d = 1'b1;
        end
`ifdef IMEM_LOADER_CSUM_EN
        csum_d = csum ^ mem_wdata;
`endif
        // in_last wins over overflow when both coincide on the final slot.
        if (pk_last_seen || (word_cnt_d == CNT_W'(DEPTH - 1))) begin
          state_d     = TERM;
          mem_we_d    = 1'b1;
          mem_waddr_d = ADDR_W'(word_cnt_d);
          mem_wdata_d = TERM_WORD;
          if (!pk_last_seen) begin
            err_ovf_d = 1'b1;
          end
        end else begin
          state_d = ASSEMBLE;
        end
      end
      TERM: begin
        state_d    = DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      err_term  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mem_we    <= mem_we_d;
      mem_waddr <= mem_waddr_d;
      mem_wdata <= mem_wdata_d;
      word_cnt  <= word_cnt_d;
      cpu_hold  <= cpu_hold_d;
      done      <= done_d;
      err_ovf   <= err_ovf_d;
      err_term  <= err_term_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of image vectors plus hand-written sequences
// for latency, overflow and asynchronous reset mid-load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_cnt;
  logic        cpu_hold;
  logic        done;
  logic        err_ovf;
  logic        err_term;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0] csum;
`endif

  imem_loader dut (
`ifdef IMEM_LOADER_CSUM_EN
    .csum      (csum),
`endif
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .word_cnt  (word_cnt),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err_ovf   (err_ovf),
    .err_term  (err_term)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    logic [63:0] bytes;
    bit          gap;
    int          nwords;
    logic [63:0] words;
    bit          term_err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0]  log_addr [0:127];
  logic [31:0] log_data [0:127];
  int          log_cyc  [0:127];
  int          wn = 0;
  int          cyc_cnt = 0;
  int          done_cyc = -1;
  logic        done_prev = 1'b0;
  logic [7:0]  sbuf [$];

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst && mem_we && wn < 128) begin
      log_addr[wn] = mem_waddr;
      log_data[wn] = mem_wdata;
      log_cyc[wn]  = cyc_cnt;
      wn++;
    end
    if (done && !done_prev) done_cyc = cyc_cnt;
    done_prev = done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
    chk({tag, "_waddr"},    32'(mem_waddr), 32'd0);
    chk({tag, "_wdata"},    mem_wdata,     32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err_ovf"},  32'(err_ovf),  32'd0);
    chk({tag, "_err_term"}, 32'(err_term), 32'd0);
`ifdef IMEM_LOADER_CSUM_EN
    chk({tag, "_csum"},     csum,          32'd0);
`endif
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_rdy"},  32'(in_ready), 32'd1);
    chk({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_start_done"}, 32'(done),     32'd0);
    chk({tag, "_start_ovf"},  32'(err_ovf),  32'd0);
    chk({tag, "_start_cnt"},  32'(word_cnt), 32'd0);
    wn = 0;
  endtask

  task automatic stream(input bit gap, input bit last_en, input int budget, output int acc);
    int cyc = 0;
    acc = 0;
    while (acc < sbuf.size() && cyc < budget) begin
      @(negedge clk);
      if (gap && cyc[0]) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = sbuf[acc];
        in_last  = last_en && (acc == sbuf.size() - 1);
        if (in_ready) acc++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int acc;
    pulse_start(tag);
    sbuf.delete();
    for (int i = 0; i < v.nbytes; i++) sbuf.push_back(v.bytes[63 - 8 * i -: 8]);
    stream(v.gap, 1'b1, 100, acc);
    chk({tag, "_accepted"}, 32'(acc), 32'(v.nbytes));
    wait_done(tag);
    chk({tag, "_nwrites"}, 32'(wn), 32'(v.nwords + 1));
    for (int k = 0; k < v.nwords && k < wn; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 32'(log_addr[k]), 32'(k));
      chk($sformatf("%s_data%0d", tag, k), log_data[k], v.words[63 - 32 * k -: 32]);
    end
    if (wn == v.nwords + 1) begin
      chk({tag, "_term_addr"}, 32'(log_addr[v.nwords]), 32'(v.nwords));
      chk({tag, "_term_data"}, log_data[v.nwords], 32'hFFFF_FFFF);
      chk({tag, "_done_lat"}, 32'(done_cyc), 32'(log_cyc[v.nwords] + 1));
    end
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(v.nwords));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_err_term"}, 32'(err_term), 32'(v.term_err));
    chk({tag, "_err_ovf"},  32'(err_ovf),  32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  vec_t vecs [0:5];

  initial begin
    int acc;
    vecs[0] = '{8, 64'h0011_2233_4455_6677, 1'b0, 2, 64'h0011_2233_4455_6677, 1'b0};
    vecs[1] = '{1, 64'hAB00_0000_0000_0000, 1'b0, 1, 64'hAB00_0000_0000_0000, 1'b0};
    vecs[2] = '{8, 64'h0011_2233_4455_6677, 1'b1, 2, 64'h0011_2233_4455_6677, 1'b0};
    vecs[3] = '{8, 64'hFFFF_FFFF_1234_5678, 1'b0, 2, 64'hFFFF_FFFF_1234_5678, 1'b1};
    vecs[4] = '{6, 64'h0102_0304_0506_0000, 1'b1, 2, 64'h0102_0304_0506_0000, 1'b0};
    vecs[5] = '{8, 64'h0F0F_0F0F_FFFF_0000, 1'b0, 2, 64'h0F0F_0F0F_FFFF_0000, 1'b0};

    rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
`ifdef IMEM_LOADER_CSUM_EN
      if (i == 5) chk("vec5_csum", csum, 32'hF0F0_0F0F);
`endif
    end

    // Overflow: 64 words offered without in_last; only 63 fit.
    pulse_start("ovf");
    sbuf.delete();
    for (int i = 0; i < 256; i++) sbuf.push_back(8'(i));
    stream(1'b0, 1'b0, 400, acc);
    chk("ovf_accepted", 32'(acc), 32'd252);
    wait_done("ovf");
    chk("ovf_nwrites", 32'(wn), 32'd64);
    for (int k = 0; k < 63 && k < wn; k++) begin
      chk($sformatf("ovf_addr%0d", k), 32'(log_addr[k]), 32'(k));
      chk($sformatf("ovf_data%0d", k), log_data[k],
          {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
    end
    if (wn == 64) begin
      chk("ovf_term_addr", 32'(log_addr[63]), 32'd63);
      chk("ovf_term_data", log_data[63], 32'hFFFF_FFFF);
    end
    chk("ovf_err_ovf",  32'(err_ovf),  32'd1);
    chk("ovf_err_term", 32'(err_term), 32'd0);
    chk("ovf_word_cnt", 32'(word_cnt), 32'd63);
    chk("ovf_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);

    // Latency, ignored mid-load start, then async reset two bytes into word 1.
    pulse_start("lat");
    in_valid = 1'b1; in_data = 8'h00;
    chk("lat_rdy_b0", 32'(in_ready), 32'd1);
    @(negedge clk); in_data = 8'h11; start = 1'b1;
    @(negedge clk); in_data = 8'h22; start = 1'b0;
    @(negedge clk); in_data = 8'h33;
    chk("lat_rdy_b3", 32'(in_ready), 32'd1);
    @(negedge clk); in_data = 8'h44;
    chk("lat_we",        32'(mem_we),    32'd1);
    chk("lat_rdy_write", 32'(in_ready),  32'd0);
    chk("lat_waddr",     32'(mem_waddr), 32'd0);
    chk("lat_wdata",     mem_wdata,      32'h0011_2233);
    chk("lat_cnt_write", 32'(word_cnt),  32'd0);
    @(negedge clk);
    chk("lat_rdy_back", 32'(in_ready),  32'd1);
    chk("lat_we_low",   32'(mem_we),    32'd0);
    chk("lat_cnt_inc",  32'(word_cnt),  32'd1);
    chk("lat_wdata_hold", mem_wdata,    32'h0011_2233);
    @(negedge clk); in_data = 8'h55;
    @(negedge clk); in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    chk("arst_nwrites", 32'(wn), 32'd1);
    @(negedge clk); rst = 1'b0;
    run_vec("restart", vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
